// File: rtl/freq_report_tx.sv
// -----------------------------------------------------------------------------
// freq_report_tx
//   Framed 8N1 UART transmitter for frequency-counter reports. A 32-bit report
//   word is latched when a send request is accepted. It goes out as a sync
//   byte followed by the four data bytes, low byte first, with bits LSB first.
//   When FREQ_REPORT_CHECKSUM_EN is defined, an XOR checksum byte of all
//   preceding bytes is appended. busy also clears the counter's interrupt, so
//   each report is sent exactly once.
//
// Parameters
//   CLK_DIV   : clock cycles per UART bit (2..65535)
//   SYNC_BYTE : first byte of every packet
//
// Ports
//   clk    in   system clock, rising edge
//   nreset in   asynchronous active-low reset
//   data   in   32-bit report word, sampled only on the accept edge
//   send   in   level request, accepted when busy is low
//   tx     out  serial line, idle high (registered)
//   busy   out  high from the cycle after accept until the frame completes
//
// Build option
//   FREQ_REPORT_CHECKSUM_EN : append the XOR checksum byte (6 bytes per frame)
// -----------------------------------------------------------------------------
module freq_report_tx #(
  parameter int unsigned CLK_DIV   = 234,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [31:0] data,
  input  logic        send,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned   TW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

`ifdef FREQ_REPORT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [31:0]   shadow_q;
  logic          tx_q;
  logic          busy_q;
  logic [2:0]    idx_d;
  logic [7:0]    byte_d;
`ifdef FREQ_REPORT_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  // Byte for a given packet position; index 5 is only reachable with checksum.
  function automatic logic [7:0] byte_sel(input logic [2:0]  idx,
                                          input logic [31:0] word,
                                          input logic [7:0]  csum);
    case (idx)
      3'd0:    byte_sel = SYNC_BYTE;
      3'd1:    byte_sel = word[7:0];
      3'd2:    byte_sel = word[15:8];
      3'd3:    byte_sel = word[23:16];
      3'd4:    byte_sel = word[31:24];
      3'd5:    byte_sel = csum;
      default: byte_sel = 8'h00;
    endcase
  endfunction

  // Next byte index and the byte that will be loaded into the shifter for it.
  always_comb begin
    idx_d = idx_q + 3'd1;
`ifdef FREQ_REPORT_CHECKSUM_EN
    byte_d = byte_sel(idx_d, shadow_q, csum_q);
`else
    byte_d = byte_sel(idx_d, shadow_q, 8'h00);
`endif
  end

  // Transmit FSM: bit timing, byte sequencing and the registered tx/busy outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= 3'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      shadow_q  <= 32'h0000_0000;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef FREQ_REPORT_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (send) begin
            // Accept: the start bit is on the line from the next cycle.
            shadow_q  <= data;
            idx_q     <= 3'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= SYNC_BYTE;
`ifdef FREQ_REPORT_CHECKSUM_EN
            // Cleared accumulator XOR the sync byte being loaded.
            csum_q    <= SYNC_BYTE;
`endif
            timer_q   <= TIMER_RELOAD;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end else begin
            timer_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        START: begin
          if (timer_q == '0) begin
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= 3'd0;
            timer_q   <= TIMER_RELOAD;
            state_q   <= DATA;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        DATA: begin
          if (timer_q == '0) begin
            timer_q <= TIMER_RELOAD;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        STOP: begin
          if (timer_q == '0) begin
            if (idx_q < LAST_IDX) begin
              idx_q   <= idx_d;
              shift_q <= byte_d;
`ifdef FREQ_REPORT_CHECKSUM_EN
              csum_q  <= csum_q ^ byte_d;
`endif
              tx_q    <= 1'b0;
              timer_q <= TIMER_RELOAD;
              state_q <= START;
            end else begin
              // Frame complete; busy drops so a held send re-accepts next cycle.
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              timer_q <= '0;
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          timer_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
